// File: rtl/seg7_scan_drv_if.sv
// Digit-code inputs and display drive outputs of the 4-digit 7-segment scanner.
// Optional macro ASICW_DIM_EN adds the dim_i brightness code.
interface seg7_scan_drv_if;
  logic [3:0] min0_i;
  logic [3:0] min1_i;
  logic [3:0] hour0_i;
  logic [3:0] hour1_i;
  logic       blink_i;
`ifdef ASICW_DIM_EN
  logic [1:0] dim_i;
`endif
  logic [6:0] seg_o;
  logic [3:0] dig_o;
  logic       colon_o;
  logic       frame_o;

`ifdef ASICW_DIM_EN
  modport master (
    output min0_i, min1_i, hour0_i, hour1_i, blink_i, dim_i,
    input  seg_o, dig_o, colon_o, frame_o
  );
  modport slave (
    input  min0_i, min1_i, hour0_i, hour1_i, blink_i, dim_i,
    output seg_o, dig_o, colon_o, frame_o
  );
`else
  modport master (
    output min0_i, min1_i, hour0_i, hour1_i, blink_i,
    input  seg_o, dig_o, colon_o, frame_o
  );
  modport slave (
    input  min0_i, min1_i, hour0_i, hour1_i, blink_i,
    output seg_o, dig_o, colon_o, frame_o
  );
`endif
endinterface

// File: rtl/seg7_scan_drv.sv
// Time-multiplexed hh:mm 7-segment driver with per-slot blanking and per-frame snapshot.
// Optional macro ASICW_DIM_EN enables 4-level brightness via dim_i.
module seg7_scan_drv #(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLANK_CYC = 16,
  parameter int unsigned LZ_BLANK  = 1
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  seg7_scan_drv_if.slave  bus
);

  localparam logic [15:0] C_LAST  = 16'(SCAN_DIV - 1);
  localparam logic [15:0] C_BLANK = 16'(BLANK_CYC);

  typedef enum logic {S_BLANK, S_SHOW} state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h40;
    endcase
    return seg;
  endfunction

  state_t           r_state;
  logic [15:0]      r_cnt;
  logic [1:0]       r_idx;
  logic [3:0][3:0]  r_snap;
  logic [6:0]       r_seg;
  logic [3:0]       r_dig;
  logic             r_colon;
  logic             r_frame;

  logic             w_wrap;
  logic             w_frame_start;
  logic             w_lz;
  logic             w_dim_ok;
  logic             w_on;
  logic [6:0]       w_seg_lit;
  logic [3:0]       w_dig_lit;

`ifdef ASICW_DIM_EN
  logic [1:0]       r_dim;
  logic [15:0]      w_off;

  // Lit length of the SHOW window: ((4 - dim) * L) >> 2, L = SCAN_DIV - BLANK_CYC.
  function automatic logic [17:0] lit_len(input logic [1:0] dim);
    logic [17:0] l;
    logic [17:0] mul;
    l   = 18'(SCAN_DIV - BLANK_CYC);
    mul = 18'(3'd4 - {1'b0, dim});
    return (mul * l) >> 2;
  endfunction

  assign w_off    = r_cnt - C_BLANK;
  assign w_dim_ok = ({2'b00, w_off} < lit_len(r_dim));
`else
  assign w_dim_ok = 1'b1;
`endif

  assign w_wrap        = (r_cnt == C_LAST);
  assign w_frame_start = (r_cnt == 16'd0) && (r_idx == 2'd0);
  assign w_lz          = (LZ_BLANK != 0) && (r_idx == 2'd3) && (r_snap[3] == 4'd0);
  assign w_on          = !w_lz && w_dim_ok;
  assign w_seg_lit     = w_on ? seg_decode(r_snap[r_idx]) : 7'd0;
  assign w_dig_lit     = w_on ? (4'b0001 << r_idx) : 4'd0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_BLANK;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_snap  <= '0;
      r_seg   <= '0;
      r_dig   <= '0;
      r_colon <= 1'b0;
      r_frame <= 1'b0;
`ifdef ASICW_DIM_EN
      r_dim   <= '0;
`endif
    end else begin
      r_cnt   <= w_wrap ? 16'd0 : r_cnt + 16'd1;
      if (w_wrap)
        r_idx <= r_idx + 2'd1;
      r_colon <= bus.blink_i;
      r_frame <= w_frame_start;

      // All four codes are captured together so a frame never mixes two times.
      if (w_frame_start) begin
        r_snap[0] <= bus.min0_i;
        r_snap[1] <= bus.min1_i;
        r_snap[2] <= bus.hour0_i;
        r_snap[3] <= bus.hour1_i;
`ifdef ASICW_DIM_EN
        r_dim     <= bus.dim_i;
`endif
      end

      case (r_state)
        S_BLANK: begin
          if (r_cnt == C_BLANK) begin
            r_state <= S_SHOW;
            r_seg   <= w_seg_lit;
            r_dig   <= w_dig_lit;
          end else begin
            r_seg   <= '0;
            r_dig   <= '0;
          end
        end
        S_SHOW: begin
          // cnt has wrapped to 0: the new slot opens with its blanking interval.
          if (r_cnt == 16'd0) begin
            r_state <= S_BLANK;
            r_seg   <= '0;
            r_dig   <= '0;
          end else begin
            r_seg   <= w_seg_lit;
            r_dig   <= w_dig_lit;
          end
        end
        default: begin
          r_state <= S_BLANK;
          r_seg   <= '0;
          r_dig   <= '0;
        end
      endcase
    end
  end

  assign bus.seg_o   = r_seg;
  assign bus.dig_o   = r_dig;
  assign bus.colon_o = r_colon;
  assign bus.frame_o = r_frame;

endmodule
